// File: rtl/conv_weight_sched_if.sv
// Weight-ROM read port and weight-stream handshake of conv_weight_sched.
// master: the scheduler side, slave: the ROM/datapath side.
interface conv_weight_sched_if #(
  parameter int unsigned NUM_KERNELS  = 4,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ROM_AW       = 8
);
  logic                              rom_en;
  logic [ROM_AW-1:0]                 rom_addr;
  logic [WEIGHT_WIDTH-1:0]           rom_dout;
  logic                              w_valid;
  logic                              w_ready;
  logic [WEIGHT_WIDTH*NUM_KERNELS-1:0] w_data;
  logic                              w_last;

  modport master (
    output rom_en, rom_addr, w_valid, w_data, w_last,
    input  rom_dout, w_ready
  );

  modport slave (
    input  rom_en, rom_addr, w_valid, w_data, w_last,
    output rom_dout, w_ready
  );
endinterface

// File: rtl/conv_weight_sched.sv
// Loads one layer's kernel weights from ROM into a bank, then replays them NUM_PASSES times.
// Optional macro WSCHED_ZERO_WHEN_IDLE_EN: zero w_data/w_last whenever w_valid is low.
module conv_weight_sched #(
  parameter int unsigned KERNEL_SIZE  = 32,
  parameter int unsigned NUM_KERNELS  = 4,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ROM_AW       = 8,
  parameter int unsigned NUM_PASSES   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  conv_weight_sched_if.master bus
);
  localparam int unsigned Total = KERNEL_SIZE * NUM_KERNELS;
  localparam int unsigned Tw    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned Pw    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int unsigned Iw    = (Total > 1) ? $clog2(Total) : 1;
  localparam int unsigned Dw    = WEIGHT_WIDTH * NUM_KERNELS;

  localparam logic [ROM_AW-1:0] LastAddr = ROM_AW'(Total - 1);
  localparam logic [Tw-1:0]     LastTap  = Tw'(KERNEL_SIZE - 1);
  localparam logic [Pw-1:0]     LastPass = Pw'(NUM_PASSES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e                  state_q;
  logic                    rom_en_q;
  logic [ROM_AW-1:0]       rom_addr_q;
  logic                    cap_en_q;
  logic [Iw-1:0]           cap_addr_q;
  logic [Tw-1:0]           tap_q;
  logic [Pw-1:0]           pass_q;
  logic                    w_valid_q;
  logic [Dw-1:0]           w_data_q;
  logic                    w_last_q;
  logic                    busy_q;
  logic                    done_q;

  logic [WEIGHT_WIDTH-1:0] bank [Total];

  logic [Tw-1:0]           next_tap;
  logic [Dw-1:0]           next_data;
  logic [Iw-1:0]           idx;

  // Tap to present after the current beat; a just-captured word is forwarded
  // so the t=0 preload never depends on the bank write having landed.
  always_comb begin
    next_tap = '0;
    if (state_q == StStream && tap_q != LastTap) begin
      next_tap = tap_q + 1'b1;
    end
    next_data = '0;
    idx       = '0;
    for (int k = 0; k < NUM_KERNELS; k++) begin
      idx = Iw'(k * KERNEL_SIZE + 32'(next_tap));
      if (cap_en_q && cap_addr_q == idx) begin
        next_data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bus.rom_dout;
      end else begin
        next_data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bank[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en_q) begin
      bank[cap_addr_q] <= bus.rom_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      cap_en_q   <= 1'b0;
      cap_addr_q <= '0;
      tap_q      <= '0;
      pass_q     <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cap_en_q   <= rom_en_q;
      cap_addr_q <= rom_addr_q[Iw-1:0];
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLoad;
            busy_q     <= 1'b1;
            rom_en_q   <= 1'b1;
            rom_addr_q <= '0;
          end
        end
        StLoad: begin
          if (rom_en_q) begin
            if (rom_addr_q == LastAddr) begin
              rom_en_q   <= 1'b0;
              rom_addr_q <= '0;
            end else begin
              rom_addr_q <= rom_addr_q + 1'b1;
            end
          end else if (cap_en_q) begin
            // Final word lands this cycle; start streaming with tap 0 preloaded.
            state_q   <= StStream;
            tap_q     <= '0;
            pass_q    <= '0;
            w_valid_q <= 1'b1;
            w_data_q  <= next_data;
            w_last_q  <= (LastTap == '0);
          end
        end
        StStream: begin
          if (w_valid_q && bus.w_ready) begin
            tap_q <= next_tap;
            if (tap_q == LastTap && pass_q == LastPass) begin
              state_q   <= StDone;
              pass_q    <= '0;
              w_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
`ifdef WSCHED_ZERO_WHEN_IDLE_EN
              w_data_q  <= '0;
              w_last_q  <= 1'b0;
`endif
            end else begin
              if (tap_q == LastTap) begin
                pass_q <= pass_q + 1'b1;
              end
              w_data_q <= next_data;
              w_last_q <= (next_tap == LastTap);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_last   = w_last_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_conv_weight_sched.sv
// Scoreboard bench for conv_weight_sched: model pushes expected beats at start,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_conv_weight_sched;
  localparam int unsigned KS    = 32;
  localparam int unsigned NK    = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned NP    = 4;
  localparam int unsigned Total = KS * NK;
  localparam int unsigned AIW   = $clog2(Total);
  localparam int unsigned DW    = W * NK;
`ifdef WSCHED_ZERO_WHEN_IDLE_EN
  localparam bit ZeroIdle = 1'b1;
`else
  localparam bit ZeroIdle = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  conv_weight_sched_if #(.NUM_KERNELS(NK), .WEIGHT_WIDTH(W), .ROM_AW(AW)) bus_if ();

  conv_weight_sched #(
    .KERNEL_SIZE (KS),
    .NUM_KERNELS (NK),
    .WEIGHT_WIDTH(W),
    .ROM_AW      (AW),
    .NUM_PASSES  (NP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rom [Total];
  always @(posedge clk) begin
    if (bus_if.rom_en) bus_if.rom_dout <= rom[bus_if.rom_addr[AIW-1:0]];
  end

  beat_t         exp_q[$];
  beat_t         last_exp;
  logic [DW-1:0] idle_expect = '0;
  int            errors       = 0;
  int            checks       = 0;
  int            beats        = 0;
  int            done_cnt     = 0;
  int            exp_addr     = 0;
  int            stall_checks = 0;
  int            stall_beat   = -1;
  int            hold_cnt     = 0;
  bit            active       = 1'b0;
  bit            ready_rand   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_en"},   bus_if.rom_en,   0);
    check({tag, "_rom_addr"}, bus_if.rom_addr, 0);
    check({tag, "_w_valid"},  bus_if.w_valid,  0);
    check({tag, "_w_data"},   bus_if.w_data,   0);
    check({tag, "_w_last"},   bus_if.w_last,   0);
    check({tag, "_busy"},     busy,            0);
    check({tag, "_done"},     done,            0);
  endtask

  // Reference: every pass replays taps 0..KS-1, kernel k drawn from rom[k*KS+t].
  task automatic push_layer();
    beat_t b;
    b = '0;
    for (int p = 0; p < NP; p++) begin
      for (int t = 0; t < KS; t++) begin
        for (int k = 0; k < NK; k++) b.data[k*W +: W] = rom[k*KS + t];
        b.last = (t == KS - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Called just after a rising edge; leaves the bench one cycle later.
  task automatic pulse_start();
    if (!active) begin
      active   = 1'b1;
      exp_addr = 0;
      push_layer();
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 5000) begin
      @(posedge clk);
      #1 c++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.rom_en) begin
        check("rom_addr_seq", bus_if.rom_addr, exp_addr);
        exp_addr++;
      end
      if (bus_if.w_valid) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (bus_if.w_ready) begin
            check("beat_data", bus_if.w_data, exp_q[0].data);
            check("beat_last", bus_if.w_last, exp_q[0].last);
            last_exp = exp_q.pop_front();
            beats++;
          end else begin
            check("stall_hold_data", bus_if.w_data, exp_q[0].data);
            check("stall_hold_last", bus_if.w_last, exp_q[0].last);
            stall_checks++;
          end
        end
      end
      if (done) begin
        check("beats_left_at_done", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        check("w_valid_at_done", bus_if.w_valid, 0);
        idle_expect = ZeroIdle ? '0 : last_exp.data;
        check("w_data_after_stream", bus_if.w_data, idle_expect);
        done_cnt++;
        active = 1'b0;
      end
    end
  end

  initial begin
    bus_if.w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_beat >= 0 && beats == stall_beat && bus_if.w_valid) begin
        hold_cnt   = 3;
        stall_beat = -1;
      end
      if (hold_cnt > 0) begin
        bus_if.w_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus_if.w_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int d0;
    for (int a = 0; a < Total; a++) rom[a] = W'(a);
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("idle");

    // Layer 1: identity ROM, always ready, latency checks.
    beats = 0;
    pulse_start();
    check("rom_en_cycle1", bus_if.rom_en, 1);
    check("rom_addr_cycle1", bus_if.rom_addr, 0);
    c = 1;
    while (!bus_if.w_valid && c < 1000) begin
      @(posedge clk);
      #1 c++;
    end
    check("first_valid_cycle", c, Total + 2);
    check("first_beat", bus_if.w_data, {8'd96, 8'd64, 8'd32, 8'd0});
    while (!done && c < 2000) begin
      @(posedge clk);
      #1 c++;
    end
    check("done_cycle", c, Total + 2 + KS * NP);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after_layer1", busy, 0);
    check("beats_layer1", beats, KS * NP);

    // Layer 2: stall at tap 10, stray starts during LOAD, STREAM and DONE.
    beats        = 0;
    stall_checks = 0;
    stall_beat   = 10;
    d0           = done_cnt;
    pulse_start();
    repeat (20) @(posedge clk);
    #1 check("w_data_in_load", bus_if.w_data, idle_expect);
    pulse_start();
    c = 0;
    while (beats < 40 && c < 2000) begin
      @(posedge clk);
      #1 c++;
    end
    pulse_start();
    wait_done("layer2");
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("single_done", done_cnt - d0, 1);
    check("no_restart_busy", busy, 0);
    check("no_restart_rom_en", bus_if.rom_en, 0);
    check("stall_cycles", stall_checks, 3);
    check("beats_layer2", beats, KS * NP);

    // Layer 3: random ROM and ready, reset mid-stream, then a clean rerun.
    for (int a = 0; a < Total; a++) rom[a] = W'($urandom);
    ready_rand = 1'b1;
    beats      = 0;
    pulse_start();
    c = 0;
    while (beats < 50 && c < 5000) begin
      @(posedge clk);
      #1 c++;
    end
    check("reached_beat50", beats >= 50, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    active      = 1'b0;
    idle_expect = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_all_zero("post_reset_idle");
    beats = 0;
    pulse_start();
    wait_done("layer4");
    @(posedge clk);
    #1;
    check("beats_after_reset", beats, KS * NP);
    check("busy_after_reset_run", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_weight_sched.md
Name: conv_weight_sched

Overview:
Sequences loading of one conv layer's kernel weights from a single-port weight ROM (1-cycle read latency) into an internal register bank. It then streams the weights to the multiply-adder array as NUM_KERNELS parallel taps per beat over a valid/ready handshake. The full weight set is replayed NUM_PASSES times (once per input feature-map pass) without re-reading the ROM. It sits between the top-level layer controller (start/done) and the conv datapath.

Parameters:
KERNEL_SIZE, 32, taps per kernel
NUM_KERNELS, 4, kernels streamed in parallel
WEIGHT_WIDTH, 8, bits per weight
ROM_AW, 8, ROM address width; must satisfy 2^ROM_AW >= KERNEL_SIZE*NUM_KERNELS
NUM_PASSES, 4, replays of the full weight set per start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin layer; sampled only in IDLE
rom_en  out  1  ROM read enable
rom_addr  out  ROM_AW  ROM read address
rom_dout  in  WEIGHT_WIDTH  ROM data, valid 1 cycle after rom_en/rom_addr
w_valid  out  1  w_data valid
w_ready  in  1  datapath accepts beat
w_data  out  WEIGHT_WIDTH*NUM_KERNELS  kernel k tap at bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
w_last  out  1  high with the last tap (t==KERNEL_SIZE-1) of each pass
busy  out  1  high in LOAD and STREAM
done  out  1  one-cycle pulse at end of layer

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters 0. Bank contents need not be reset. Reset mid-operation aborts immediately. After release, the block waits in IDLE.
- TOTAL = KERNEL_SIZE*NUM_KERNELS. The bank is indexed by ROM address: kernel k, tap t lives at k*KERNEL_SIZE+t.
- IDLE: on start=1 -> LOAD, addr counter=0.
- LOAD: rom_en=1; rom_addr = 0,1,...,TOTAL-1 on consecutive cycles.
  - A 1-cycle-delayed copy of rom_en/rom_addr captures rom_dout into bank[addr].
  - rom_en deasserts after address TOTAL-1. The final capture occurs the following cycle, then -> STREAM.
  - LOAD lasts TOTAL+1 cycles.
- STREAM: tap counter t (0..KERNEL_SIZE-1), pass counter p (0..NUM_PASSES-1).
  - w_data, w_valid and w_last are registered.
  - w_valid=1 from the first STREAM cycle, with t=0 data preloaded.
  - Handshake = w_valid&&w_ready. On handshake: t increments; at t==KERNEL_SIZE-1, t wraps to 0 and p increments. The next beat's data is presented the following cycle, so back-to-back beats occur at full rate.
  - With w_ready=0: w_data, w_last and the counters hold, and w_valid stays 1 (no drop, no duplicate).
  - Handshake on t==KERNEL_SIZE-1 && p==NUM_PASSES-1 -> DONE; w_valid=0 next cycle.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- start is ignored outside IDLE, including in the DONE cycle.
- Latency with w_ready=1: start sampled at edge 0; rom_addr=0 in cycle 1; first w_valid in cycle TOTAL+2 (130 at defaults); last beat at cycle TOTAL+1+KERNEL_SIZE*NUM_PASSES; done in the next cycle.
- Counter widths are sized with $clog2 of their limits. No wrap-around beyond the defined ranges.

Optional Feature:
- Macro: WSCHED_ZERO_WHEN_IDLE_EN.
- Defined: w_data and w_last are forced to 0 whenever w_valid=0 (power/debug hygiene).
- Undefined: w_data holds its last presented value when w_valid=0.
- Handshake timing is identical in both cases.

Test Plan:
- ROM[a]=a, defaults, w_ready=1, pulse start -> rom_addr 0..127 on cycles 1..128; first beat w_data={96,64,32,0} at cycle 130; beat 5={101,69,37,5}; w_last on beats 31,63,95,127; 128 beats total; done pulses once; busy low afterwards.
- Same ROM, w_ready=0 for 3 cycles at tap 10 of pass 0 -> w_data holds {106,74,42,10} with w_valid=1; next beat {107,75,43,11}; beat count still 128.
- start pulsed during LOAD, during STREAM and in the DONE cycle -> no restart; rom_addr sequence uninterrupted; exactly one done.
- rst_n asserted at beat 50 -> all outputs 0 immediately (async); after release, outputs stay 0 until a new start, which reloads from rom_addr 0 and produces a full correct 128-beat stream.
- NUM_PASSES=1, KERNEL_SIZE=8, NUM_KERNELS=2 -> rom_addr 0..15; 8 beats, first {8,0}; w_last on beat 7; done at cycle 26.
- WSCHED_ZERO_WHEN_IDLE_EN defined -> w_data==0 in IDLE, LOAD and after the last beat; undefined -> w_data holds {127,95,63,31} after the stream ends.
